uart_transmitter_top: RTL and testbench
=======================================

// Module: uart_transmitter_top
// PURPOSE
//  Serial-bus UART transmit path: a free-running baud-tick generator feeding a framing transmitter.
//  Accepts one DATA_WIDTH-bit word per txStart pulse and shifts it out on tx as an 8N1-style frame.
//  Sits between the bus-side master/slave logic and the physical serial line.
// PARAMETERS
//  DATA_WIDTH  8            payload bits per frame
//  BAUD_RATE   19200        line bit rate, bits/s
//  CLK_FREQ    100_000_000  clk frequency, Hz (10 ns period)
// PORTS
//  clk       in   1           single system clock, all logic on posedge
//  rstN      in   1           synchronous, active-high reset (1 = reset), sampled on posedge clk
//  dataIn    in   DATA_WIDTH  word to send; sampled only in the accept cycle
//  txStart   in   1           request strobe; honoured only while tx_ready=1
//  tx        out  1           serial line, idle high
//  tx_ready  out  1           1 = idle, new word may be requested
//  baudTick  out  1           one-clk pulse at 16 x BAUD_RATE (debug/observe)
// BEHAVIOUR
//  Baud generator: DIV = CLK_FREQ/(16*BAUD_RATE), integer truncation (325 at defaults).
//   - counter 0..DIV-1, free-running; baudTick=1 for one clk when counter==DIV-1; counter wraps to 0.
//  Transmitter FSM states: IDLE, START, DATA, STOP; 4-bit tick counter; bit index counter.
//   - IDLE: tx=1, tx_ready=1. txStart=1 -> latch dataIn into shift reg, clear counters, go START next clk.
//   - START: tx=0. After 16 baudTicks -> DATA, index=0.
//   - DATA: tx=shift[0] (LSB first). Each 16 baudTicks shift right; after DATA_WIDTH bits -> STOP.
//   - STOP: tx=1. After 16 baudTicks -> IDLE; tx_ready rises the same clk state becomes IDLE.
//   - tx_ready is 0 in every non-IDLE state, including the clk after acceptance.
//   - tx and tx_ready registered (no combinational path from txStart).
//  Bit timing: each bit = exactly 16 baudTicks. Start bit is aligned to the free-running tick, so its
//   length is 15*DIV+1..16*DIV clks; every later bit is exactly 16*DIV clks (5200 at defaults).
//  txStart while busy: ignored, no queuing; dataIn changes while busy have no effect.
//  txStart held high in IDLE: a new frame starts the clk after tx_ready rises (back-to-back allowed).
//  Reset: tx=1, tx_ready=1, baudTick=0, state IDLE, all counters/shift reg 0, on the next posedge;
//   mid-frame reset aborts the frame with no partial stop bit.
// CONFIGURATION
//  Macro UART_TX_PARITY_EN:
//   defined   -> PARITY state between DATA and STOP; tx = even parity (XOR of latched word) for 16 ticks;
//                frame = 1+DATA_WIDTH+1+1 bits (11 at defaults).
//   undefined -> no parity bit; frame = 1+DATA_WIDTH+1 bits (10 at defaults).
// STRUCTURE
//  Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP), OVERSAMPLE=16 constant,
//   function baud_div(clk_freq, baud_rate) returning the divisor.
//  Sub-module uart_baud_rate_gen (clk, rstN, baudTick; params BAUD_RATE, CLK_FREQ);
//   top holds the FSM, shift reg and counters.
// TESTING
//  1 Reset: rstN=1 for 2 clks -> tx=1, tx_ready=1, baudTick=0; release -> baudTick every 325 clks.
//  2 Single frame dataIn=8'hA5, txStart 1 clk -> tx_ready=0 next clk; tx = 0,1,0,1,0,0,1,0,1,1;
//    bits 2..10 each 5200 clks wide.
//  3 Busy ignore: txStart with dataIn=8'h3C mid-frame of 8'h0F -> 8'h0F frame unchanged; no second frame.
//  4 Back-to-back: 10 random words, each sent when tx_ready=1 -> decoded bytes match, line idles high after.
//  5 Mid-frame reset during DATA -> next clk tx=1, tx_ready=1; next txStart sends a clean full frame.
//  6 With UART_TX_PARITY_EN, dataIn=8'h07 -> parity bit 1 before stop; 8'h03 -> parity bit 0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit path.
// The optional parity stage is enabled with the UART_TX_PARITY_EN macro.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_t;

    localparam int unsigned OVERSAMPLE = 16;

    function automatic int unsigned baud_div(input int unsigned clk_freq,
                                             input int unsigned baud_rate);
        return clk_freq / (OVERSAMPLE * baud_rate);
    endfunction

endpackage

// File: rtl/uart_baud_rate_gen.sv
// Free-running oversample tick generator.
// Emits a one-clk baudTick at OVERSAMPLE x BAUD_RATE.
module uart_baud_rate_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_RATE = 19200,
    parameter int unsigned CLK_FREQ  = 100_000_000
) (
    input  logic clk,
    input  logic rstN,
    output logic baudTick
);

    localparam int unsigned DIV   = baud_div(CLK_FREQ, BAUD_RATE);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_count;
    logic             w_wrap;

    assign w_wrap   = (r_count == CNT_W'(DIV - 1));
    assign baudTick = w_wrap;

    always_ff @(posedge clk) begin
        if (rstN) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter_top.sv
// UART transmit path: baud tick generator plus framing FSM (start, data LSB first, stop).
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter_top
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 19200,
    parameter int unsigned CLK_FREQ   = 100_000_000
) (
    input  logic                  clk,
    input  logic                  rstN,
    input  logic [DATA_WIDTH-1:0] dataIn,
    input  logic                  txStart,
    output logic                  tx,
    output logic                  tx_ready,
    output logic                  baudTick
);

    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  w_baud_tick;
    logic                  w_last_tick;
    logic [DATA_WIDTH-1:0] w_next_shift;

    uart_state_t           r_state;
    logic [3:0]            r_tick_cnt;
    logic [IDX_W-1:0]      r_bit_idx;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  r_tx_ready;
`ifdef UART_TX_PARITY_EN
    logic                  r_parity;
`endif

    uart_baud_rate_gen #(
        .BAUD_RATE (BAUD_RATE),
        .CLK_FREQ  (CLK_FREQ)
    ) u_baud_gen (
        .clk      (clk),
        .rstN     (rstN),
        .baudTick (w_baud_tick)
    );

    assign baudTick     = w_baud_tick;
    assign tx           = r_tx;
    assign tx_ready     = r_tx_ready;
    assign w_last_tick  = w_baud_tick && (r_tick_cnt == 4'(OVERSAMPLE - 1));
    assign w_next_shift = r_shift >> 1;

    always_ff @(posedge clk) begin
        if (rstN) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_tx       <= 1'b1;
            r_tx_ready <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity   <= 1'b0;
`endif
        end else begin
            // Tick counter wraps naturally at 16, so each bit boundary is a wrap.
            if (r_state != IDLE && w_baud_tick) begin
                r_tick_cnt <= r_tick_cnt + 4'd1;
            end

            case (r_state)
                IDLE: begin
                    if (txStart) begin
                        r_shift    <= dataIn;
`ifdef UART_TX_PARITY_EN
                        r_parity   <= ^dataIn;
`endif
                        r_tick_cnt <= '0;
                        r_bit_idx  <= '0;
                        r_state    <= START;
                        r_tx       <= 1'b0;
                        r_tx_ready <= 1'b0;
                    end
                end
                START: begin
                    if (w_last_tick) begin
                        r_state   <= DATA;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_last_tick) begin
                        if (r_bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            r_shift   <= w_next_shift;
                            r_tx      <= w_next_shift[0];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (w_last_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_last_tick) begin
                        r_state    <= IDLE;
                        r_tx       <= 1'b1;
                        r_tx_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_tx       <= 1'b1;
                    r_tx_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter_top.sv
// Self-checking bench for uart_transmitter_top, run with a reduced divider (DIV=5) to keep frames short.
// Honours UART_TX_PARITY_EN for the expected frame length.
module tb_uart_transmitter_top;

    localparam int DIV      = 5;            // 100e6 / (16 * 1.2e6) = 5.2 -> 5
    localparam int BIT_CLKS = 16 * DIV;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       rstN = 1'b1;
    logic       txStart = 1'b0;
    logic [7:0] dataIn = 8'h00;
    logic       tx;
    logic       tx_ready;
    logic       baudTick;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    typedef struct {
        logic [7:0] data;
        logic       par;
        bit         inject;
    } vec_t;

    vec_t vecs[12];

    uart_transmitter_top #(
        .DATA_WIDTH (8),
        .BAUD_RATE  (1_200_000),
        .CLK_FREQ   (100_000_000)
    ) dut (
        .clk      (clk),
        .rstN     (rstN),
        .dataIn   (dataIn),
        .txStart  (txStart),
        .tx       (tx),
        .tx_ready (tx_ready),
        .baudTick (baudTick)
    );

    always #5 clk = ~clk;

    // Posedges since the last reset edge; the DUT baud counter equals cyc % DIV.
    always @(posedge clk) begin
        if (rstN) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input bit ok, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input bit inject, input string tag);
        logic [10:0] fr;
        int waited;
        int a;
        int start_c;
        int end_c;
        int errs;
        int rdy_errs;
        waited = 0;
        while (tx_ready !== 1'b1 && waited < 4 * NBITS * BIT_CLKS) begin
            @(negedge clk);
            waited++;
        end
        check($sformatf("%s_ready_wait", tag), tx_ready === 1'b1, int'(tx_ready), 1);
`ifdef UART_TX_PARITY_EN
        fr = {1'b1, p, d, 1'b0};
`else
        fr = {1'b0, 1'b1, d, 1'b0};
        if (p === 1'bx) fr[10] = 1'b0;
`endif
        dataIn  = d;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        dataIn  = ~d;
        a = cyc;
        check($sformatf("%s_accept_ready", tag), tx_ready === 1'b0, int'(tx_ready), 0);
        start_c = a;
        for (int j = 0; j < NBITS; j++) begin
            end_c    = (j == 0) ? ((a / DIV + 1) * DIV + 15 * DIV) : (start_c + BIT_CLKS);
            errs     = 0;
            rdy_errs = 0;
            while (cyc < end_c) begin
                if (tx !== fr[j]) errs++;
                if (tx_ready !== 1'b0) rdy_errs++;
                if (inject && j == 4 && cyc == start_c) begin
                    dataIn  = 8'h3C;
                    txStart = 1'b1;
                end else if (inject) begin
                    txStart = 1'b0;
                end
                @(negedge clk);
            end
            check($sformatf("%s_bit%0d", tag, j), errs == 0 && rdy_errs == 0, errs + rdy_errs, 0);
            start_c = end_c;
        end
        check($sformatf("%s_end_tx", tag), tx === 1'b1, int'(tx), 1);
        check($sformatf("%s_end_ready", tag), tx_ready === 1'b1, int'(tx_ready), 1);
    endtask

    initial begin
        int errs;
        int ticks;

        vecs[0]  = '{8'hA5, 1'b0, 1'b0};
        vecs[1]  = '{8'h0F, 1'b0, 1'b1};
        vecs[2]  = '{8'h00, 1'b0, 1'b0};
        vecs[3]  = '{8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{8'h01, 1'b1, 1'b0};
        vecs[5]  = '{8'h80, 1'b1, 1'b0};
        vecs[6]  = '{8'h55, 1'b0, 1'b0};
        vecs[7]  = '{8'hAA, 1'b0, 1'b0};
        vecs[8]  = '{8'h13, 1'b1, 1'b0};
        vecs[9]  = '{8'hC3, 1'b0, 1'b0};
        vecs[10] = '{8'h07, 1'b1, 1'b0};
        vecs[11] = '{8'h03, 1'b0, 1'b0};

        // Reset held for two clocks
        rstN = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_tx", tx === 1'b1, int'(tx), 1);
        check("rst_ready", tx_ready === 1'b1, int'(tx_ready), 1);
        check("rst_baudtick", baudTick === 1'b0, int'(baudTick), 0);
        rstN = 1'b0;

        errs  = 0;
        ticks = 0;
        for (int k = 1; k <= 4 * DIV; k++) begin
            @(negedge clk);
            if (baudTick === 1'b1) ticks++;
            if (baudTick !== ((cyc % DIV) == DIV - 1)) errs++;
        end
        check("baud_phase", errs == 0, errs, 0);
        check("baud_count", ticks == 4, ticks, 4);

        // Frames: first single, second with busy injection, rest back-to-back
        for (int i = 0; i < 12; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].inject, $sformatf("v%0d", i));
            if (vecs[i].inject) begin
                errs = 0;
                for (int k = 0; k < 3 * BIT_CLKS; k++) begin
                    if (tx !== 1'b1 || tx_ready !== 1'b1) errs++;
                    @(negedge clk);
                end
                check("busy_no_second", errs == 0, errs, 0);
            end
        end

        // Reset in the middle of the data bits
        dataIn  = 8'hC3;
        txStart = 1'b1;
        @(negedge clk);
        txStart = 1'b0;
        repeat (3 * BIT_CLKS) @(negedge clk);
        check("mid_busy", tx_ready === 1'b0, int'(tx_ready), 0);
        rstN = 1'b1;
        @(negedge clk);
        check("mid_rst_tx", tx === 1'b1, int'(tx), 1);
        check("mid_rst_ready", tx_ready === 1'b1, int'(tx_ready), 1);
        check("mid_rst_baudtick", baudTick === 1'b0, int'(baudTick), 0);
        rstN = 1'b0;
        errs = 0;
        for (int k = 0; k < 2 * BIT_CLKS; k++) begin
            if (tx !== 1'b1) errs++;
            @(negedge clk);
        end
        check("mid_rst_idle", errs == 0, errs, 0);
        send_frame(8'h5A, 1'b0, 1'b0, "post_rst");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
